fetch_unit: RTL

Instruction fetch stage that owns the architectural program counter and sits directly upstream of the branch unit. It drives the current PC to the branch unit and to instruction memory, fetches one instruction at a time over a request/grant/response handshake, and presents it to decode with a valid/ready handshake. When decode accepts an instruction, the PC is updated from the next-PC value returned by the branch unit (PC+4 or branch target).

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_perf_cnt.sv | 48 ++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_t    : fetch FSM state encoding
//   XLEN / ILEN      : address and instruction widths
//   RESET_PC_DEFAULT : PC loaded on reset unless overridden
//   pc_aligned()     : true when a PC is word aligned

package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        FAULT
    } fetch_state_t;

    function automatic logic pc_aligned(input logic [XLEN-1:0] pc);
        return pc[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: fetch performance counters. Only instantiated when
// FETCH_PERF_CNT_EN is defined.
//   clk         : clock
//   rst_n       : asynchronous active-low reset
//   hs_i        : decode accepted an instruction this cycle
//   taken_i     : branch-taken flag qualifying hs_i
//   fetch_cnt_o : number of accepted instructions (wraps)
//   taken_cnt_o : number of accepted instructions with a taken branch (wraps)

module fetch_perf_cnt
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hs_i,
    input  logic            taken_i,
    output logic [XLEN-1:0] fetch_cnt_o,
    output logic [XLEN-1:0] taken_cnt_o
);

    logic [XLEN-1:0] fetch_cnt_d, fetch_cnt_q;
    logic [XLEN-1:0] taken_cnt_d, taken_cnt_q;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (hs_i) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
            if (taken_i) begin
                taken_cnt_d = taken_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            taken_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign taken_cnt_o = taken_cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage owning the architectural PC.
// Fetches one instruction at a time over req/gnt/rvalid and holds it for
// decode under valid/ready. On acceptance the PC loads the branch unit's
// next-PC; a misaligned next-PC parks the stage in a sticky fault.
// Optional macro FETCH_PERF_CNT_EN adds fetch_cnt_o / taken_cnt_o.
//   clk, rst_n        : clock, asynchronous active-low reset
//   pc_o              : current PC (to branch unit)
//   pc_next_i         : next PC from branch unit
//   branch_taken_i    : branch-taken flag (perf counters only)
//   imem_req_o/addr_o : fetch request / address (addr is pc_o)
//   imem_gnt_i        : request accepted
//   imem_rvalid_i     : read data valid
//   imem_rdata_i      : instruction word
//   instr_o           : held instruction
//   instr_pc_o        : PC of instr_o
//   instr_valid_o     : instr_o valid
//   instr_ready_i     : decode accepts instr_o
//   fetch_fault_o     : sticky misaligned-PC fault

module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] pc_o,
    input  logic [XLEN-1:0] pc_next_i,
    input  logic            branch_taken_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [ILEN-1:0] imem_rdata_i,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
`ifdef FETCH_PERF_CNT_EN
    output logic [XLEN-1:0] fetch_cnt_o,
    output logic [XLEN-1:0] taken_cnt_o,
`endif
    output logic            fetch_fault_o
);

    fetch_state_t    state_d, state_q;
    logic [XLEN-1:0] pc_d, pc_q;
    logic [ILEN-1:0] instr_d, instr_q;
    logic [XLEN-1:0] instr_pc_d, instr_pc_q;
    logic            req_q, valid_q, fault_q;
    logic            hs;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        hs         = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    instr_d    = imem_rdata_i;
                    instr_pc_d = pc_q;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready_i) begin
                    hs      = 1'b1;
                    // PC wraps naturally; only alignment is policed.
                    pc_d    = pc_next_i;
                    state_d = pc_aligned(pc_next_i) ? REQ : FAULT;
                end
            end
            FAULT: state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    // Output flags are registered from the next state so they line up with
    // state_q without any decode after the flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            req_q      <= (state_d == REQ);
            valid_q    <= (state_d == HOLD);
            fault_q    <= (state_d == FAULT);
        end
    end

    assign pc_o          = pc_q;
    assign imem_addr_o   = pc_q;
    assign imem_req_o    = req_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = valid_q;
    assign fetch_fault_o = fault_q;

`ifdef FETCH_PERF_CNT_EN
    // No handshake can occur in FAULT, so the counters freeze there.
    fetch_perf_cnt u_perf_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .hs_i        (hs),
        .taken_i     (branch_taken_i),
        .fetch_cnt_o (fetch_cnt_o),
        .taken_cnt_o (taken_cnt_o)
    );
`else
    logic unused_perf;
    assign unused_perf = branch_taken_i ^ hs;
`endif

endmodule
